// File: rtl/eth_mii_rx.sv
// eth_mii_rx: MII receive framer with CRC-32, length and destination checks; ETH_RX_STATS_EN adds frame counters
module eth_mii_rx #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  eth_rx_data,
  input  logic        eth_rx_dv,
  input  logic        eth_rx_er,
  input  logic [47:0] mac_addr_i,
  input  logic        promisc_i,
`ifdef ETH_RX_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_good,
  output logic [15:0] stat_crc,
  output logic [15:0] stat_len,
`endif
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_done,
  output logic        rx_good,
  output logic        rx_crc_err,
  output logic        rx_len_err,
  output logic        rx_dst_match,
  output logic [10:0] rx_len
);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP, END} state_t;
  state_t          state_q, state_d;
  logic [3:0]      lo_q, lo_d;
  logic            phase_q, phase_d, ovf_q, ovf_d, er_q, er_d, in_frame_q, in_frame_d;
  logic            uc_q, uc_d, bc_q, bc_d, fin;
  logic [10:0]     cnt_q, cnt_d, rx_len_q, rx_len_d;
  logic [31:0]     crc_q, crc_d;
  logic [3:0][7:0] dly_q, dly_d;
  logic [7:0]      rx_data_q, rx_data_d, byte_v, mac_v;
  logic            rx_valid_q, rx_valid_d, rx_sof_q, rx_sof_d, rx_done_q, rx_done_d;
  logic            rx_good_q, rx_good_d, rx_crc_err_q, rx_crc_err_d;
  logic            rx_len_err_q, rx_len_err_d, rx_dst_match_q, rx_dst_match_d;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    phase_d = phase_q;
    ovf_d = ovf_q;
    er_d = er_q;
    in_frame_d = in_frame_q;
    uc_d = uc_q;
    bc_d = bc_q;
    cnt_d = cnt_q;
    crc_d = crc_q;
    dly_d = dly_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    rx_sof_d = 1'b0;
    rx_done_d = 1'b0;
    rx_good_d = rx_good_q;
    rx_crc_err_d = rx_crc_err_q;
    rx_len_err_d = rx_len_err_q;
    rx_dst_match_d = rx_dst_match_q;
    rx_len_d = rx_len_q;
    fin = 1'b0;
    byte_v = {eth_rx_data, lo_q};
    mac_v = 8'(mac_addr_i >> {3'd5 - cnt_q[2:0], 3'b000});
    case (state_q)
      WAIT_IDLE: state_d = eth_rx_dv ? WAIT_IDLE : IDLE;
      IDLE: if (eth_rx_dv) begin
        state_d = eth_rx_data == 4'h5 ? PREAMBLE : DROP;
        in_frame_d = 1'b0;
      end
      PREAMBLE: if (!eth_rx_dv) state_d = IDLE;
      else if (eth_rx_data == 4'hd) begin
        state_d = DATA;
        phase_d = 1'b0;
        cnt_d = '0;
        crc_d = '1;
        ovf_d = 1'b0;
        er_d = 1'b0;
        uc_d = 1'b1;
        bc_d = 1'b1;
        in_frame_d = 1'b1;
      end else if (eth_rx_data != 4'h5) state_d = DROP;
      DATA: if (!eth_rx_dv) fin = 1'b1;
      else begin
        er_d = er_q | eth_rx_er;
        phase_d = !phase_q;
        if (!phase_q) lo_d = eth_rx_data;
        else if (cnt_q == MAX_L) begin
          cnt_d = cnt_q + 11'd1;
          ovf_d = 1'b1;
          state_d = DROP;
        end else begin
          cnt_d = cnt_q + 11'd1;
          crc_d = crc_byte(crc_q, byte_v);
          dly_d = {dly_q[2:0], byte_v};
          uc_d = uc_q & (cnt_q >= 11'd6 || byte_v == mac_v);
          bc_d = bc_q & (cnt_q >= 11'd6 || byte_v == 8'hff);
          // the four newest bytes stay buffered so the FCS never reaches rx_data
          if (cnt_q >= 11'd4) begin
            rx_valid_d = 1'b1;
            rx_sof_d = cnt_q == 11'd4;
            rx_data_d = dly_q[3];
          end
        end
      end
      DROP: if (!eth_rx_dv) begin
        fin = in_frame_q;
        state_d = IDLE;
      end
      END: state_d = IDLE;
      default: state_d = WAIT_IDLE;
    endcase
    if (fin) begin
      state_d = END;
      rx_done_d = 1'b1;
      rx_crc_err_d = crc_q != 32'hDEBB20E3;
      rx_len_err_d = ovf_q || cnt_q < MIN_L;
      rx_len_d = cnt_q < 11'd4 ? '0 : cnt_q - 11'd4;
      rx_dst_match_d = cnt_q >= 11'd6 && (promisc_i || uc_q || bc_q);
      rx_good_d = !rx_crc_err_d && !rx_len_err_d && !er_q && !(state_q == DATA && phase_q);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_IDLE;
      lo_q <= '0;
      phase_q <= 1'b0;
      ovf_q <= 1'b0;
      er_q <= 1'b0;
      in_frame_q <= 1'b0;
      uc_q <= 1'b0;
      bc_q <= 1'b0;
      cnt_q <= '0;
      crc_q <= '1;
      dly_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_sof_q <= 1'b0;
      rx_done_q <= 1'b0;
      rx_good_q <= 1'b0;
      rx_crc_err_q <= 1'b0;
      rx_len_err_q <= 1'b0;
      rx_dst_match_q <= 1'b0;
      rx_len_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      phase_q <= phase_d;
      ovf_q <= ovf_d;
      er_q <= er_d;
      in_frame_q <= in_frame_d;
      uc_q <= uc_d;
      bc_q <= bc_d;
      cnt_q <= cnt_d;
      crc_q <= crc_d;
      dly_q <= dly_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_sof_q <= rx_sof_d;
      rx_done_q <= rx_done_d;
      rx_good_q <= rx_good_d;
      rx_crc_err_q <= rx_crc_err_d;
      rx_len_err_q <= rx_len_err_d;
      rx_dst_match_q <= rx_dst_match_d;
      rx_len_q <= rx_len_d;
    end
  end
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_sof = rx_sof_q;
  assign rx_done = rx_done_q;
  assign rx_good = rx_good_q;
  assign rx_crc_err = rx_crc_err_q;
  assign rx_len_err = rx_len_err_q;
  assign rx_dst_match = rx_dst_match_q;
  assign rx_len = rx_len_q;
`ifdef ETH_RX_STATS_EN
  logic [15:0] stat_good_q, stat_good_d, stat_crc_q, stat_crc_d, stat_len_q, stat_len_d;
  always_comb begin
    stat_good_d = stat_clr ? '0 : (rx_done_q && rx_good_q && ~&stat_good_q) ? stat_good_q + 16'd1 : stat_good_q;
    stat_crc_d = stat_clr ? '0 : (rx_done_q && rx_crc_err_q && ~&stat_crc_q) ? stat_crc_q + 16'd1 : stat_crc_q;
    stat_len_d = stat_clr ? '0 : (rx_done_q && rx_len_err_q && ~&stat_len_q) ? stat_len_q + 16'd1 : stat_len_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_good_q <= '0;
      stat_crc_q <= '0;
      stat_len_q <= '0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_crc_q <= stat_crc_d;
      stat_len_q <= stat_len_d;
    end
  end
  assign stat_good = stat_good_q;
  assign stat_crc = stat_crc_q;
  assign stat_len = stat_len_q;
`endif
endmodule

// File: tb/tb_eth_mii_rx.sv
// tb_eth_mii_rx: directed frame scenarios for eth_mii_rx
`timescale 1ns/1ps
module tb_eth_mii_rx;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [3:0] eth_rx_data = '0;
  logic eth_rx_dv = 1'b0, eth_rx_er = 1'b0, promisc_i = 1'b0;
  logic [47:0] mac_addr_i = 48'h000102030405;
  logic [7:0] rx_data;
  logic rx_valid, rx_sof, rx_done, rx_good, rx_crc_err, rx_len_err, rx_dst_match;
  logic [10:0] rx_len;
`ifdef ETH_RX_STATS_EN
  logic stat_clr = 1'b0;
  logic [15:0] stat_good, stat_crc, stat_len;
`endif
  int vectors = 0, miscompares = 0;
  int sof_n, sof_pos, done_n;
  logic [7:0] frm[$], got[$], a[$];
  logic s_good, s_crc, s_len_err, s_dst;
  logic [10:0] s_len;

  eth_mii_rx dut (
    .clk(clk), .reset_n(reset_n), .eth_rx_data(eth_rx_data), .eth_rx_dv(eth_rx_dv),
    .eth_rx_er(eth_rx_er), .mac_addr_i(mac_addr_i), .promisc_i(promisc_i),
`ifdef ETH_RX_STATS_EN
    .stat_clr(stat_clr), .stat_good(stat_good), .stat_crc(stat_crc), .stat_len(stat_len),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_done(rx_done),
    .rx_good(rx_good), .rx_crc_err(rx_crc_err), .rx_len_err(rx_len_err),
    .rx_dst_match(rx_dst_match), .rx_len(rx_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_sof) begin sof_n++; sof_pos = got.size(); end
    if (rx_valid) got.push_back(rx_data);
    if (rx_done) begin
      done_n++;
      s_good = rx_good; s_crc = rx_crc_err; s_len_err = rx_len_err; s_dst = rx_dst_match; s_len = rx_len;
    end
  end

  task automatic clr();
    got.delete(); sof_n = 0; sof_pos = -1; done_n = 0;
    s_good = 1'bx; s_crc = 1'bx; s_len_err = 1'bx; s_dst = 1'bx; s_len = 'x;
  endtask

  // dst, fixed source 02:00:00:00:00:01, patterned payload up to n bytes, then FCS
  task automatic mk_frame(input logic [47:0] dst, input int n);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(8'(dst >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) frm.push_back(8'(48'h020000000001 >> (40 - 8 * i)));
    for (int i = 12; i < n; i++) frm.push_back(8'(i * 7 + 3));
    c = '1;
    foreach (frm[j]) for (int k = 0; k < 8; k++) c = (c >> 1) ^ ((c[0] ^ frm[j][k]) ? 32'hEDB88320 : 32'h0);
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(8'(c >> (8 * i)));
  endtask

  task automatic send_frame(input int extra, input int er_at, input int rst_at);
    logic [3:0] nib[$];
    for (int i = 0; i < 15; i++) nib.push_back(4'h5);
    nib.push_back(4'hd);
    foreach (frm[j]) begin nib.push_back(frm[j][3:0]); nib.push_back(frm[j][7:4]); end
    if (extra != 0) nib.push_back(4'ha);
    foreach (nib[i]) begin
      @(negedge clk);
      eth_rx_dv = 1'b1; eth_rx_data = nib[i]; eth_rx_er = (i == er_at);
      if (i == rst_at) begin #2 reset_n = 1'b0; #4 reset_n = 1'b1; clr(); end
    end
    @(negedge clk);
    eth_rx_dv = 1'b0; eth_rx_er = 1'b0; eth_rx_data = '0;
    repeat (24) @(negedge clk);
  endtask

  function automatic int diffs();
    int d = 0;
    foreach (got[i]) if (i >= frm.size() || got[i] !== frm[i]) d++;
    return d;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if ({rx_valid, rx_sof, rx_done, rx_good, rx_crc_err, rx_len_err, rx_dst_match} !== 7'b0) begin miscompares++; $display("FAIL reset_flags got=%b exp=0000000", {rx_valid, rx_sof, rx_done, rx_good, rx_crc_err, rx_len_err, rx_dst_match}); end
    vectors++; if ({rx_data, rx_len} !== 19'h0) begin miscompares++; $display("FAIL reset_data_len got=%h/%0d exp=0/0", rx_data, rx_len); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_good();
    mk_frame(48'h000102030405, 60); clr(); send_frame(0, -1, -1);
    vectors++; if (done_n !== 1) begin miscompares++; $display("FAIL good_done got=%0d exp=1", done_n); end
    vectors++; if (got.size() !== 60 || diffs() !== 0) begin miscompares++; $display("FAIL good_data got=%0d bytes/%0d diffs exp=60/0", got.size(), diffs()); end
    vectors++; if (sof_n !== 1 || sof_pos !== 0) begin miscompares++; $display("FAIL good_sof got=%0d@%0d exp=1@0", sof_n, sof_pos); end
    vectors++; if ({s_good, s_crc, s_len_err, s_dst, s_len} !== {4'b1001, 11'd60}) begin miscompares++; $display("FAIL good_status got=%b_%0d exp=1001_60", {s_good, s_crc, s_len_err, s_dst}, s_len); end
    vectors++; if ({rx_good, rx_len} !== {1'b1, 11'd60}) begin miscompares++; $display("FAIL good_hold got=%b_%0d exp=1_60", rx_good, rx_len); end
  endtask

  task automatic test_crc_err();
    mk_frame(48'h000102030405, 60); frm[30] ^= 8'h04; clr(); send_frame(0, -1, -1);
    vectors++; if (got.size() !== 60 || diffs() !== 0) begin miscompares++; $display("FAIL crc_data got=%0d bytes/%0d diffs exp=60/0", got.size(), diffs()); end
    vectors++; if ({s_good, s_crc, s_len_err, s_dst, s_len} !== {4'b0101, 11'd60}) begin miscompares++; $display("FAIL crc_status got=%b_%0d exp=0101_60", {s_good, s_crc, s_len_err, s_dst}, s_len); end
  endtask

  task automatic test_dst();
    mk_frame('1, 60); clr(); send_frame(0, -1, -1);
    vectors++; if ({s_good, s_dst} !== 2'b11) begin miscompares++; $display("FAIL dst_bcast got=%b exp=11", {s_good, s_dst}); end
    mk_frame(48'h000000000009, 60); clr(); send_frame(0, -1, -1);
    vectors++; if ({s_good, s_dst} !== 2'b10) begin miscompares++; $display("FAIL dst_other got=%b exp=10", {s_good, s_dst}); end
    promisc_i = 1'b1; clr(); send_frame(0, -1, -1); promisc_i = 1'b0;
    vectors++; if ({s_good, s_dst} !== 2'b11) begin miscompares++; $display("FAIL dst_promisc got=%b exp=11", {s_good, s_dst}); end
  endtask

  task automatic test_runt();
    mk_frame(48'h000102030405, 40); clr(); send_frame(0, -1, -1);
    vectors++; if (got.size() !== 40 || diffs() !== 0) begin miscompares++; $display("FAIL runt_data got=%0d bytes/%0d diffs exp=40/0", got.size(), diffs()); end
    vectors++; if ({s_good, s_crc, s_len_err, s_dst, s_len} !== {4'b0011, 11'd40}) begin miscompares++; $display("FAIL runt_status got=%b_%0d exp=0011_40", {s_good, s_crc, s_len_err, s_dst}, s_len); end
    frm = {8'h00, 8'h01}; clr(); send_frame(0, -1, -1);
    vectors++; if (done_n !== 1 || got.size() !== 0) begin miscompares++; $display("FAIL short_done got=%0d done/%0d bytes exp=1/0", done_n, got.size()); end
    vectors++; if ({s_good, s_crc, s_len_err, s_dst, s_len} !== {4'b0110, 11'd0}) begin miscompares++; $display("FAIL short_status got=%b_%0d exp=0110_0", {s_good, s_crc, s_len_err, s_dst}, s_len); end
  endtask

  task automatic test_overlength();
    mk_frame(48'h000102030405, 1600); clr(); send_frame(0, -1, -1);
    vectors++; if (got.size() !== 1514 || diffs() !== 0) begin miscompares++; $display("FAIL long_data got=%0d bytes/%0d diffs exp=1514/0", got.size(), diffs()); end
    vectors++; if (done_n !== 1 || {s_good, s_len_err} !== 2'b01) begin miscompares++; $display("FAIL long_status got=%0d done %b exp=1 done 01", done_n, {s_good, s_len_err}); end
  endtask

  task automatic test_errors();
    mk_frame(48'h000102030405, 60); clr(); send_frame(1, -1, -1);
    vectors++; if (got.size() !== 60 || diffs() !== 0) begin miscompares++; $display("FAIL align_data got=%0d bytes/%0d diffs exp=60/0", got.size(), diffs()); end
    vectors++; if ({s_good, s_crc, s_len_err, s_dst, s_len} !== {4'b0001, 11'd60}) begin miscompares++; $display("FAIL align_status got=%b_%0d exp=0001_60", {s_good, s_crc, s_len_err, s_dst}, s_len); end
    clr(); send_frame(0, 16 + 60, -1);
    vectors++; if (got.size() !== 60 || diffs() !== 0) begin miscompares++; $display("FAIL er_data got=%0d bytes/%0d diffs exp=60/0", got.size(), diffs()); end
    vectors++; if ({s_good, s_crc, s_len_err, s_dst, s_len} !== {4'b0001, 11'd60}) begin miscompares++; $display("FAIL er_status got=%b_%0d exp=0001_60", {s_good, s_crc, s_len_err, s_dst}, s_len); end
  endtask

  task automatic test_reset_mid();
    mk_frame(48'h000102030405, 60); clr(); send_frame(0, -1, 16 + 50);
    vectors++; if (got.size() !== 0 || done_n !== 0) begin miscompares++; $display("FAIL rstmid_quiet got=%0d bytes/%0d done exp=0/0", got.size(), done_n); end
    clr(); send_frame(0, -1, -1);
    vectors++; if (done_n !== 1 || got.size() !== 60 || diffs() !== 0) begin miscompares++; $display("FAIL rstmid_next got=%0d done/%0d bytes exp=1/60", done_n, got.size()); end
    vectors++; if ({s_good, s_crc, s_len_err, s_dst, s_len} !== {4'b1001, 11'd60}) begin miscompares++; $display("FAIL rstmid_status got=%b_%0d exp=1001_60", {s_good, s_crc, s_len_err, s_dst}, s_len); end
  endtask

  task automatic test_back_to_back();
    int d;
    mk_frame(48'h000102030405, 60); a = frm; clr(); send_frame(0, -1, -1);
    mk_frame('1, 64); send_frame(0, -1, -1);
    d = 0;
    for (int i = 0; i < 124 && i < got.size(); i++) if (got[i] !== (i < 60 ? a[i] : frm[i - 60])) d++;
    vectors++; if (done_n !== 2 || got.size() !== 124 || d !== 0) begin miscompares++; $display("FAIL b2b got=%0d done/%0d bytes/%0d diffs exp=2/124/0", done_n, got.size(), d); end
    vectors++; if ({s_good, s_dst, s_len} !== {2'b11, 11'd64}) begin miscompares++; $display("FAIL b2b_status got=%b_%0d exp=11_64", {s_good, s_dst}, s_len); end
  endtask

`ifdef ETH_RX_STATS_EN
  task automatic test_stats();
    @(negedge clk); stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
    mk_frame(48'h000102030405, 60);
    repeat (3) send_frame(0, -1, -1);
    frm[20] ^= 8'h01;
    repeat (2) send_frame(0, -1, -1);
    vectors++; if ({stat_good, stat_crc, stat_len} !== {16'd3, 16'd2, 16'd0}) begin miscompares++; $display("FAIL stats got=%0d/%0d/%0d exp=3/2/0", stat_good, stat_crc, stat_len); end
    @(negedge clk); stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0; @(negedge clk);
    vectors++; if ({stat_good, stat_crc, stat_len} !== 48'h0) begin miscompares++; $display("FAIL stats_clr got=%0d/%0d/%0d exp=0/0/0", stat_good, stat_crc, stat_len); end
  endtask
`endif

  initial begin
    clr();
    test_reset();
    test_good();
    test_crc_err();
    test_dst();
    test_runt();
    test_overlength();
    test_errors();
    test_reset_mid();
    test_back_to_back();
`ifdef ETH_RX_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/eth_mii_rx.md
Name: eth_mii_rx

Overview:
- MII receive-side framer; counterpart to the UDP/MII transmitter used for sample readout.
- Accepts nibbles from the PHY on eth_rx_clk and strips preamble/SFD and FCS.
- Delivers frame bytes with start-of-frame marking and checks CRC-32, length and destination MAC.
- Reports a one-cycle end-of-frame status strobe, so host commands can later arrive over Ethernet instead of the serial port.

Parameters:
- MAX_LEN, 1518, maximum frame length in bytes, destination MAC through FCS inclusive.
- MIN_LEN, 64, minimum frame length in bytes, FCS inclusive.

Ports:
- clk  in  1  eth_rx_clk from PHY; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- eth_rx_data  in  4  MII receive nibble; low nibble of each byte first.
- eth_rx_dv  in  1  MII receive data valid.
- eth_rx_er  in  1  MII receive error.
- mac_addr_i  in  48  local MAC; byte 0 is [47:40].
- promisc_i  in  1  1 = every destination matches.
- rx_data  out  8  frame byte, FCS excluded.
- rx_valid  out  1  rx_data valid this cycle; at most one pulse per 2 cycles.
- rx_sof  out  1  with rx_valid on byte 0.
- rx_done  out  1  one-cycle end-of-frame strobe.
- rx_good  out  1  status: no CRC, length, alignment or eth_rx_er error.
- rx_crc_err  out  1  status: FCS mismatch.
- rx_len_err  out  1  status: runt or overlength.
- rx_dst_match  out  1  status: destination equals mac_addr_i, FF:FF:FF:FF:FF:FF, or promisc_i=1.
- rx_len  out  11  status: byte count excluding FCS.

Behaviour:
- Reset: all outputs 0; FSM to WAIT_IDLE.
- rx_good, rx_crc_err, rx_len_err, rx_dst_match and rx_len update only on the rx_done cycle and then hold.
- FSM:
  - WAIT_IDLE: go to IDLE when eth_rx_dv=0. This prevents locking onto a frame already in progress after reset.
  - IDLE: on eth_rx_dv=1 with nibble 5, go to PREAMBLE. Any other nibble goes to DROP.
  - PREAMBLE: nibble 5 stays. Nibble D goes to DATA with byte phase 0. Any other nibble goes to DROP. dv=0 goes to IDLE with no rx_done.
  - DATA: assemble bytes (low nibble, then high). Each completed byte enters the CRC and a 4-byte delay line. The delay line's oldest byte is emitted on rx_data/rx_valid on the cycle after the high nibble of byte i+4 is sampled, which strips the FCS.
  - DATA exits: dv=0 goes to END. Byte count reaching MAX_LEN+1 goes to DROP, setting the overlength flag and stopping rx_valid.
  - DROP: ignore input until dv=0, then go to END if the frame was in DATA, otherwise to IDLE.
  - END: rx_done=1 for one cycle, then go to IDLE.
- rx_done timing: asserted on the cycle after dv is sampled low. The 4 buffered bytes are discarded as FCS.
- Errors:
  - eth_rx_er=1 while dv=1 in DATA: latch error; bytes keep flowing; rx_good=0 at END.
  - dv falls on byte phase 1 (odd nibble count): alignment error; rx_good=0; partial nibble dropped.
  - Frame shorter than 4 bytes after SFD: rx_done still asserted, rx_len=0, rx_len_err=1.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wise LSB-first over every byte after the SFD, FCS included. A correct frame leaves the register at 0xDEBB20E3.
- rx_len = total bytes − 4, saturating at 0.
- rx_len_err: total bytes < MIN_LEN or > MAX_LEN.
- rx_dst_match: compares bytes 0-5 as they arrive. Frames shorter than 6 bytes → 0.
- rx_good = !crc_err & !len_err & !er_seen & !align_err. rx_dst_match does not affect rx_good.
- Back-to-back frames: new frame detection is allowed on the cycle after END. The IFG is at least 24 cycles on the wire.

Optional Feature:
- Macro: ETH_RX_STATS_EN.
- Defined: adds outputs stat_good, stat_crc and stat_len (16 bits each, saturating at 0xFFFF), plus input stat_clr (synchronous clear to 0).
  - Counters increment on rx_done according to rx_good, rx_crc_err and rx_len_err. A frame with both CRC and length errors increments both counters.
- Undefined: these ports and counters do not exist; all other behaviour is unchanged.

Test Plan:
- Good frame: 7×0x55, 0xD5, 60-byte frame to mac_addr_i=00:01:02:03:04:05 + correct FCS → 60 rx_valid pulses, rx_sof on byte 0, rx_done with rx_good=1, rx_len=60, rx_dst_match=1, rx_crc_err=0.
- Same frame with one payload bit flipped → identical data stream; at rx_done rx_crc_err=1, rx_good=0.
- Broadcast dst FF×6 vs dst 00:00:00:00:00:09 with promisc_i=0 → rx_dst_match=1 then 0. With promisc_i=1 the second frame → rx_dst_match=1.
- Runt: 40-byte frame + FCS → rx_len_err=1, rx_len=40. 1600-byte frame → output stops after the MAX_LEN-th byte (rx_valid deasserts); rx_done after dv falls; rx_len_err=1.
- Odd nibble count (one extra nibble before dv falls) and eth_rx_er pulse mid-frame → rx_good=0 in both cases. reset_n pulsed mid-frame with dv high → no rx_valid until dv low; the next frame is received good.
- ETH_RX_STATS_EN: 3 good + 2 CRC-bad frames → stat_good=3, stat_crc=2; stat_clr → all 0.
